// File: rtl/fetch_unit.sv
// fetch_unit: PC generator + fetch stage feeding a 1-cycle synchronous instr_mem; program-load path while idle.
// Latency: start_i/redirect_i to valid_o = 1 cycle, 1 instr/cycle. Backpressure: ready_i low re-issues pc_o, outputs hold.
// Optional FETCH_STATS_EN adds saturating transfer/stall counters (fetch_cnt_o, stall_cnt_o).

package fetch_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  rd;
        logic [15:0] imm;
    } instruction_s;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic [addr_width_p-1:0] start_pc_i,
    input  logic                    halt_i,
    input  logic                    load_en_i,
    input  logic [addr_width_p-1:0] load_addr_i,
    input  instruction_s            load_instr_i,
    input  logic                    redirect_i,
    input  logic [addr_width_p-1:0] redirect_pc_i,
    output logic [addr_width_p-1:0] imem_addr_o,
    output logic                    imem_wen_o,
    output instruction_s            imem_instr_o,
    input  instruction_s            imem_instr_i,
    output instruction_s            instr_o,
    output logic [addr_width_p-1:0] pc_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]             fetch_cnt_o,
    output logic [31:0]             stall_cnt_o
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    localparam logic [addr_width_p-1:0] PC_ONE = {{(addr_width_p-1){1'b0}}, 1'b1};

    state_e                  state_r;
    logic [addr_width_p-1:0] fetch_pc_r;
    logic [addr_width_p-1:0] pc_r;
    logic                    valid_r;

    logic start_ok;
    logic stall;
    logic xfer;

    // A load in the same cycle as start keeps the port, so start is dropped.
    assign start_ok = (state_r == IDLE) && start_i && !load_en_i;
    assign stall    = valid_r && !ready_i;
    assign xfer     = valid_r && ready_i;

    always_comb begin
        imem_addr_o  = load_addr_i;
        imem_wen_o   = 1'b0;
        imem_instr_o = load_instr_i;
        if (state_r == IDLE) begin
            imem_wen_o = load_en_i;
            if (start_ok) begin
                imem_addr_o = start_pc_i;
            end
        end else if (redirect_i) begin
            imem_addr_o = redirect_pc_i;
        end else if (stall) begin
            // Re-read the held PC so the memory output stays on the stalled instruction.
            imem_addr_o = pc_r;
        end else begin
            imem_addr_o = fetch_pc_r;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= '0;
            pc_r       <= '0;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ok) begin
                        state_r    <= FETCH;
                        pc_r       <= start_pc_i;
                        fetch_pc_r <= start_pc_i + PC_ONE;
                        valid_r    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (halt_i) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end else if (redirect_i) begin
                        pc_r       <= redirect_pc_i;
                        fetch_pc_r <= redirect_pc_i + PC_ONE;
                        valid_r    <= 1'b1;
                    end else if (!stall) begin
                        pc_r       <= fetch_pc_r;
                        fetch_pc_r <= fetch_pc_r + PC_ONE;
                        valid_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign instr_o = imem_instr_i;
    assign pc_o    = pc_r;
    assign valid_o = valid_r;
    assign busy_o  = (state_r == FETCH);

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else if (start_ok) begin
            fetch_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else if (state_r == FETCH) begin
            if (xfer && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_r;
    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous instr_mem model, higher-level PC/stream model checked every negedge,
// plus directed literal checks taken 1 time unit after posedges.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] start_pc_i = '0;
    logic          halt_i = 1'b0;
    logic          load_en_i = 1'b0;
    logic [AW-1:0] load_addr_i = '0;
    instruction_s  load_instr_i = '0;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_pc_i = '0;
    logic [AW-1:0] imem_addr_o;
    logic          imem_wen_o;
    instruction_s  imem_instr_o;
    instruction_s  imem_instr_i;
    instruction_s  instr_o;
    logic [AW-1:0] pc_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          busy_o;
`ifdef FETCH_STATS_EN
    logic [31:0]   fetch_cnt_o;
    logic [31:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.addr_width_p(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .start_pc_i   (start_pc_i),
        .halt_i       (halt_i),
        .load_en_i    (load_en_i),
        .load_addr_i  (load_addr_i),
        .load_instr_i (load_instr_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_wen_o   (imem_wen_o),
        .imem_instr_o (imem_instr_o),
        .imem_instr_i (imem_instr_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    // Synchronous instruction memory, one-cycle read latency.
    logic [31:0]  mem  [DEPTH];
    logic [31:0]  gold [DEPTH];
    instruction_s mem_q = '0;

    always @(posedge clk) begin
        if (imem_wen_o) mem[imem_addr_o] <= imem_instr_o;
        mem_q <= mem[imem_addr_o];
    end
    assign imem_instr_i = mem_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what decode must see, tracked as plain integers.
    int     m_pc    = 0;
    int     m_fpc   = 0;
    bit     m_busy  = 1'b0;
    bit     m_valid = 1'b0;
    longint m_fcnt  = 0;
    longint m_scnt  = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = 0; m_fpc = 0; m_busy = 1'b0; m_valid = 1'b0; m_fcnt = 0; m_scnt = 0;
        end else if (!m_busy) begin
            if (start_i && !load_en_i) begin
                m_busy = 1'b1; m_valid = 1'b1;
                m_pc = int'(start_pc_i); m_fpc = (m_pc + 1) % DEPTH;
                m_fcnt = 0; m_scnt = 0;
            end
        end else begin
            if (m_valid && ready_i && m_fcnt < CNT_MAX) m_fcnt++;
            if (m_valid && !ready_i && m_scnt < CNT_MAX) m_scnt++;
            if (halt_i) begin
                m_busy = 1'b0; m_valid = 1'b0;
            end else if (redirect_i) begin
                m_pc = int'(redirect_pc_i); m_fpc = (m_pc + 1) % DEPTH; m_valid = 1'b1;
            end else if (!(m_valid && !ready_i)) begin
                m_pc = m_fpc; m_fpc = (m_fpc + 1) % DEPTH; m_valid = 1'b1;
            end
        end
    end

    function automatic int exp_addr();
        if (!m_busy) return (start_i && !load_en_i) ? int'(start_pc_i) : int'(load_addr_i);
        if (redirect_i) return int'(redirect_pc_i);
        if (m_valid && !ready_i) return m_pc;
        return m_fpc;
    endfunction

    always @(negedge clk) begin
        check("valid", 32'(valid_o), 32'(m_valid));
        check("busy", 32'(busy_o), 32'(m_busy));
        if (m_valid) begin
            check("pc", 32'(pc_o), 32'(m_pc));
            check("instr", instr_o, gold[m_pc]);
        end
        if (!reset_n) check("pc_in_reset", 32'(pc_o), 32'd0);
        check("imem_wen", 32'(imem_wen_o), 32'(!m_busy && load_en_i));
        check("imem_addr", 32'(imem_addr_o), 32'(exp_addr()));
`ifdef FETCH_STATS_EN
        check("fetch_cnt", fetch_cnt_o, 32'(m_fcnt));
        check("stall_cnt", stall_cnt_o, 32'(m_scnt));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [13:0] rdy_pat;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            gold[i] = 32'hA500_0000 | 32'(i);
            mem[i] <= 32'hA500_0000 | 32'(i);
        end
        step(2);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pc", 32'(pc_o), 32'd0);
        reset_n = 1'b1;

        // Program load 0..7; last load collides with start, load must win.
        for (int i = 0; i < 8; i++) begin
            load_en_i    = 1'b1;
            load_addr_i  = AW'(i);
            load_instr_i = 32'h1000_0000 + 32'(i) * 32'h11;
            gold[i]      = 32'h1000_0000 + 32'(i) * 32'h11;
            if (i == 7) begin start_i = 1'b1; start_pc_i = 10'd5; end
            step(1);
        end
        start_i = 1'b0; load_en_i = 1'b0;
        check("start_ignored_busy", 32'(busy_o), 32'd0);
        check("load7_mem", mem[7], 32'h1000_0077);

        // Start at 0 with decode always ready.
        start_i = 1'b1; start_pc_i = 10'd0; ready_i = 1'b1;
        step(1);
        start_i = 1'b0;
        check("first_pc", 32'(pc_o), 32'h0);
        check("first_instr", instr_o, 32'h1000_0000);
        check("first_valid", 32'(valid_o), 32'd1);
        step(1);
        check("pc1_instr", instr_o, 32'h1000_0011);
        step(3);
        ready_i = 1'b0;
        step(3);
        check("stall_pc", 32'(pc_o), 32'h4);
        check("stall_instr", instr_o, 32'h1000_0044);
        check("stall_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        step(1);
        check("after_stall_pc", 32'(pc_o), 32'h5);

        // Redirect to 0x3F0.
        redirect_i = 1'b1; redirect_pc_i = 10'h3F0;
        step(1);
        redirect_i = 1'b0;
        check("redir_pc", 32'(pc_o), 32'h3F0);
        check("redir_instr", instr_o, 32'hA500_03F0);
        step(1);
        check("redir_next_pc", 32'(pc_o), 32'h3F1);

        // Halt beats a same-cycle redirect.
        halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 10'h100;
        step(1);
        halt_i = 1'b0; redirect_i = 1'b0;
        check("halt_valid", 32'(valid_o), 32'd0);
        check("halt_busy", 32'(busy_o), 32'd0);

        // Wrap at the top of the address space; load attempt while fetching.
        start_i = 1'b1; start_pc_i = 10'h3FF;
        step(1);
        start_i = 1'b0;
        check("wrap_pc_top", 32'(pc_o), 32'h3FF);
        load_en_i = 1'b1; load_addr_i = 10'd2; load_instr_i = 32'hDEAD_BEEF;
        step(1);
        load_en_i = 1'b0;
        check("wrap_pc_zero", 32'(pc_o), 32'h0);
        step(1);
        check("fetch_load_ignored", mem[2], 32'h1000_0022);
        halt_i = 1'b1;
        step(1);
        halt_i = 1'b0;

        // 10 transfers and 4 stall cycles from 0x20.
        start_i = 1'b1; start_pc_i = 10'h20; ready_i = 1'b1;
        step(1);
        start_i = 1'b0;
        rdy_pat = 14'b10_1101_1101_1011;
        for (int k = 0; k < 14; k++) begin
            ready_i = rdy_pat[k];
            step(1);
        end
        check("pattern_pc", 32'(pc_o), 32'h2A);
`ifdef FETCH_STATS_EN
        check("stats_fetch", fetch_cnt_o, 32'd10);
        check("stats_stall", stall_cnt_o, 32'd4);
`endif
        halt_i = 1'b1; ready_i = 1'b1;
        step(1);
        halt_i = 1'b0;
        start_i = 1'b1; start_pc_i = 10'd0;
        step(1);
        start_i = 1'b0;
`ifdef FETCH_STATS_EN
        check("stats_clear_fetch", fetch_cnt_o, 32'd0);
        check("stats_clear_stall", stall_cnt_o, 32'd0);
`endif
        step(2);

        // Asynchronous reset mid-stream.
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_o), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_pc", 32'(pc_o), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        start_i = 1'b1; start_pc_i = 10'd3;
        step(1);
        start_i = 1'b0;
        check("post_rst_instr", instr_o, 32'h1000_0033);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
